// File: rtl/wave_pkg.sv
// Shared types and helpers for the WaveGen flash->SDRAM loader / SDRAM->DAC player.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, HIGH/LOW constants, default widths, pack ratio and width helpers.
package wave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int DEF_FLASH_AW  = 24;
    localparam int DEF_FLASH_DW  = 8;
    localparam int DEF_SDRAM_AW  = 24;
    localparam int DEF_SDRAM_DW  = 32;
    localparam int DEF_DAC_DW    = 20;
    localparam int DEF_SYNC_DIV  = 100;
    localparam int DEF_MAX_OUTST = 4;

    // Flash beats packed into one SDRAM word.
    function automatic int pack_ratio(input int sdram_dw, input int flash_dw);
        return sdram_dw / flash_dw;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wave_packer.sv
// Packs flash bytes into SDRAM words: rising edge of flash_dv shifts a byte into the word LSBs.
// Latency: word_vld pulses one cycle after the edge that delivers the last byte of a word.
// Backpressure: none; the caller only requests flash reads while the SDRAM write side has room.
// Ports: mclk/rst clock and sync reset; en gates edge capture; clr restarts packing;
//        flash_dv/flash_data flash read side; byte_stb accepted-byte strobe; word_vld/word_dat packed word.
module wave_packer
    import wave_pkg::*;
#(
    parameter int FLASH_DW = DEF_FLASH_DW,
    parameter int SDRAM_DW = DEF_SDRAM_DW
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                flash_dv,
    input  logic [FLASH_DW-1:0] flash_data,
    output logic                byte_stb,
    output logic                word_vld,
    output logic [SDRAM_DW-1:0] word_dat
);
    localparam int R  = pack_ratio(SDRAM_DW, FLASH_DW);
    localparam int CW = cnt_w(R);
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    logic          dv_q;
    logic [CW-1:0] cnt;

    // flash_dv is a level; only its rising edge marks a new byte.
    assign byte_stb = en & flash_dv & ~dv_q;

    always_ff @(posedge mclk) begin
        if (rst) begin
            dv_q     <= LOW;
            cnt      <= '0;
            word_vld <= LOW;
            word_dat <= '0;
        end else begin
            dv_q     <= flash_dv;
            word_vld <= LOW;
            if (clr) begin
                cnt      <= '0;
                word_dat <= '0;
            end else if (byte_stb) begin
                // First byte of a word migrates up to the MSBs.
                word_dat <= (word_dat << FLASH_DW) | SDRAM_DW'(flash_data);
                if (cnt == LAST) begin
                    cnt      <= '0;
                    word_vld <= HIGH;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wave_flow_ctrl.sv
// Loads a waveform from flash into SDRAM, then plays it to the DAC one word per sync tick.
// Latency: flash/SDRAM strobes combinational from state; dac_dv/dac_data pass straight through.
// Backpressure: flash reads wait on flash_rstatus/sdram_wstatus; a blocked tick in PLAY counts an underrun.
// Ports: mclk/rst; start/stop/cfg_* control; busy/loaded/cfg_err/underrun_cnt status;
//        flash_* read port; sdram_w* write port; sdram_r* read port; dac_* sample stream.
module wave_flow_ctrl
    import wave_pkg::*;
#(
    parameter int FLASH_AW  = DEF_FLASH_AW,
    parameter int FLASH_DW  = DEF_FLASH_DW,
    parameter int SDRAM_AW  = DEF_SDRAM_AW,
    parameter int SDRAM_DW  = DEF_SDRAM_DW,
    parameter int DAC_DW    = DEF_DAC_DW,
    parameter int SYNC_DIV  = DEF_SYNC_DIV,
    parameter int MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_reload,
    input  logic                cfg_loop,
    input  logic [SDRAM_AW-1:0] cfg_len,
    output logic                busy,
    output logic                loaded,
    output logic                cfg_err,
    output logic [15:0]         underrun_cnt,
    output logic                flash_rd,
    output logic [FLASH_AW-1:0] flash_addr,
    input  logic                flash_rstatus,
    input  logic [FLASH_DW-1:0] flash_data,
    input  logic                flash_dv,
    output logic                sdram_wren,
    output logic [SDRAM_AW-1:0] sdram_waddr,
    output logic [SDRAM_DW-1:0] sdram_wdata,
    input  logic                sdram_wstatus,
    output logic                sdram_rd,
    output logic [SDRAM_AW-1:0] sdram_raddr,
    input  logic [SDRAM_DW-1:0] sdram_rdata,
    input  logic                sdram_rdv,
    input  logic                sdram_rstatus,
    output logic                dac_start,
    output logic                dac_en,
    output logic                dac_dv,
    output logic [DAC_DW-1:0]   dac_data,
    input  logic                dac_waitrequest
);
    localparam int SW = cnt_w(SYNC_DIV);
    localparam int OW = cnt_w(MAX_OUTST + 1);

    state_t              state;
    logic                stopped;
    logic [SDRAM_AW-1:0] len_q;
    logic [SDRAM_AW-1:0] widx;
    logic [SDRAM_AW-1:0] raddr;
    logic [FLASH_AW-1:0] faddr;
    logic [SW-1:0]       sync_cnt;
    logic [OW-1:0]       outst;
    logic [15:0]         urun;
    logic                loaded_q;
    logic                cfg_err_q;

    logic                byte_stb;
    logic                word_vld;
    logic [SDRAM_DW-1:0] word_dat;
    logic                in_load, in_play, playing, idle_like;
    logic                last_wr, rd_last, pk_clr;

    assign in_load   = (state == ST_LOAD);
    assign in_play   = (state == ST_PLAY);
    assign playing   = in_play | (state == ST_DRAIN);
    assign idle_like = (state == ST_IDLE) | (state == ST_DONE);

    assign last_wr = sdram_wren & (widx == len_q - 1'b1);
    assign rd_last = (raddr == len_q - 1'b1);
    // Packer restarts on every accepted start that goes to LOAD and after the final word.
    assign pk_clr  = (idle_like & start & ~stop & (cfg_len != '0) & (cfg_reload | ~loaded_q)) | last_wr;

    wave_packer #(
        .FLASH_DW (FLASH_DW),
        .SDRAM_DW (SDRAM_DW)
    ) u_packer (
        .mclk       (mclk),
        .rst        (rst),
        .en         (in_load),
        .clr        (pk_clr),
        .flash_dv   (flash_dv),
        .flash_data (flash_data),
        .byte_stb   (byte_stb),
        .word_vld   (word_vld),
        .word_dat   (word_dat)
    );

    assign busy         = ~idle_like;
    assign loaded       = loaded_q;
    assign cfg_err      = cfg_err_q;
    assign underrun_cnt = urun;
    assign flash_rd     = in_load & flash_rstatus & sdram_wstatus;
    assign flash_addr   = faddr;
    // A word completing just after a stop is dropped rather than written.
    assign sdram_wren   = word_vld & in_load;
    assign sdram_waddr  = widx;
    assign sdram_wdata  = word_dat;
    assign dac_start    = playing & (sync_cnt == '0);
    assign dac_en       = playing;
    assign sdram_rd     = in_play & dac_start & sdram_rstatus & ~dac_waitrequest &
                          (outst < OW'(MAX_OUTST));
    assign sdram_raddr  = raddr;
    assign dac_dv       = sdram_rdv;
    assign dac_data     = sdram_rdata[DAC_DW-1:0];

    generate
        if (DAC_DW < SDRAM_DW) begin : g_rdata_hi
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^sdram_rdata[SDRAM_DW-1:DAC_DW];
        end
    endgenerate

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            stopped   <= LOW;
            len_q     <= '0;
            widx      <= '0;
            raddr     <= '0;
            faddr     <= '0;
            sync_cnt  <= '0;
            outst     <= '0;
            urun      <= '0;
            loaded_q  <= LOW;
            cfg_err_q <= LOW;
        end else begin
            if (playing)
                sync_cnt <= (sync_cnt == SW'(SYNC_DIV - 1)) ? '0 : sync_cnt + 1'b1;
            else
                sync_cnt <= '0;

            if (sdram_rd & ~sdram_rdv)
                outst <= outst + 1'b1;
            else if (~sdram_rd & sdram_rdv & (outst != '0))
                outst <= outst - 1'b1;

            if (in_play & dac_start & ~sdram_rd & (urun != 16'hFFFF))
                urun <= urun + 1'b1;

            if (byte_stb)
                faddr <= faddr + 1'b1;
            if (sdram_wren)
                widx <= widx + 1'b1;
            if (sdram_rd)
                raddr <= rd_last ? '0 : raddr + 1'b1;

            // State assignments below take precedence over the counter updates above.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start & ~stop) begin
                        if (cfg_len == '0) begin
                            cfg_err_q <= HIGH;
                        end else begin
                            cfg_err_q <= LOW;
                            len_q     <= cfg_len;
                            stopped   <= LOW;
                            if (cfg_reload | ~loaded_q) begin
                                state    <= ST_LOAD;
                                loaded_q <= LOW;
                                widx     <= '0;
                                faddr    <= '0;
                            end else begin
                                state <= ST_PLAY;
                                raddr <= '0;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        state   <= ST_DRAIN;
                        stopped <= HIGH;
                    end else if (last_wr) begin
                        state    <= ST_PLAY;
                        loaded_q <= HIGH;
                        faddr    <= '0;
                        widx     <= '0;
                        raddr    <= '0;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state   <= ST_DRAIN;
                        stopped <= HIGH;
                    end else if (sdram_rd & rd_last & ~cfg_loop) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outst == '0)
                        state <= stopped ? ST_IDLE : ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
